// File: rtl/dilithium_op_responder.sv
// Core-side responder for the 4-bit Dilithium command interface: decodes host
// opcodes and runs payload store, payload load or an engine operation.
`timescale 1ns/1ps

module dilithium_op_responder #(
  parameter int SEED_WORDS = 8,
  parameter int PK_WORDS   = 328,
  parameter int SK_WORDS   = 636,
  parameter int SIG_WORDS  = 605,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        op_in,
  input  logic              op_valid_in,
  output logic              ready_out,
  input  logic [31:0]       data_in,
  input  logic              valid_in,
  output logic              ready_rcv_out,
  output logic [31:0]       data_out,
  output logic              valid_out,
  input  logic              ready_rcv_in,
  output logic [1:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              eng_start,
  output logic [2:0]        eng_op,
  input  logic              eng_done,
  output logic              err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_STOR     = 3'd1;
  localparam logic [2:0] S_LD_RD    = 3'd2;
  localparam logic [2:0] S_LD_HOLD  = 3'd3;
  localparam logic [2:0] S_EX_START = 3'd4;
  localparam logic [2:0] S_EX_WAIT  = 3'd5;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] last_idx;
  logic              at_last;
  logic              accept;
  logic              op_stor;
  logic              op_load;
  logic              op_illegal;
  logic              op_exec;
  logic              stor_hs;
  logic              load_hs;
  logic              vld_p1;
  logic [31:0]       data_p1;

  function automatic logic [ADDR_W-1:0] last_index(input logic [1:0] sel);
    case (sel)
      2'b00:   return ADDR_W'(PK_WORDS - 1);
      2'b01:   return ADDR_W'(SK_WORDS - 1);
      2'b10:   return ADDR_W'(SIG_WORDS - 1);
      default: return ADDR_W'(SEED_WORDS - 1);
    endcase
  endfunction

  assign accept     = ready_out & op_valid_in;
  assign op_stor    = (op_in[3:2] == 2'b11);
  assign op_load    = (op_in[3:2] == 2'b10);
  assign op_illegal = (op_in == 4'b0110);
  assign op_exec    = ~op_in[3] & (op_in != 4'b0000) & ~op_illegal;

  assign last_idx = last_index(mem_sel);
  assign at_last  = (cnt == last_idx);
  assign stor_hs  = (state == S_STOR) & valid_in;
  assign load_hs  = (state == S_LD_HOLD) & ready_rcv_in;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (op_stor)      state_nxt = S_STOR;
          else if (op_load) state_nxt = S_LD_RD;
          else if (op_exec) state_nxt = S_EX_START;
        end
      end
      S_STOR:     if (stor_hs && at_last) state_nxt = S_IDLE;
      S_LD_RD:    state_nxt = S_LD_HOLD;
      S_LD_HOLD:  if (ready_rcv_in) state_nxt = at_last ? S_IDLE : S_LD_RD;
      S_EX_START: state_nxt = S_EX_WAIT;
      S_EX_WAIT:  if (eng_done) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mem_sel <= 2'b00;
      eng_op  <= 3'b000;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
        if (op_in[3])    mem_sel <= op_in[1:0];
        if (op_exec)     eng_op  <= op_in[2:0];
        if (op_illegal)  err     <= 1'b1;
      end else if ((stor_hs || load_hs) && !at_last) begin
        cnt <= cnt + ADDR_W'(1);
      end
      if ((state == S_EX_WAIT) && eng_done) eng_op <= 3'b000;
    end
  end

  // Read-data stage: RAM answers one cycle after mem_re; capture it on the
  // first LD_HOLD cycle and replay the captured word while the host stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= (state == S_LD_RD);
      if (vld_p1) data_p1 <= mem_rdata;
    end
  end

  assign ready_out     = (state == S_IDLE);
  assign ready_rcv_out = (state == S_STOR);
  assign mem_we        = stor_hs;
  assign mem_wdata     = (state == S_STOR) ? data_in : 32'd0;
  assign mem_re        = (state == S_LD_RD);
  assign mem_addr      = ((state == S_STOR) || (state == S_LD_RD)) ? cnt : '0;
  assign valid_out     = (state == S_LD_HOLD);
  assign data_out      = vld_p1 ? mem_rdata : data_p1;
  assign eng_start     = (state == S_EX_START);

endmodule
